// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin req/gnt arbiter sharing the single-port data memory between
// the CPU path (m0) and the debug loader (m1), with a burst cap and registered read return.
module dm_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [31:0]       m0_pc,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [31:0]       m1_pc,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_din,
   output logic [31:0]       dm_pc,
   input  logic [DATA_W-1:0] dm_dout,
   output logic [1:0]        owner
);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
   state_t        state, state_n;
   logic          last_owner;
   logic [CW-1:0] burst_cnt;
   logic          cap, xfer0, xfer1;
   assign m0_gnt = state == OWN0;
   assign m1_gnt = state == OWN1;
   assign owner  = state;
   assign xfer0  = m0_gnt & m0_req;
   assign xfer1  = m1_gnt & m1_req;
   assign cap    = burst_cnt >= CW'(MAX_BURST - 1);
   // dm sees the owner's inputs even in a release bubble; only dm_we is gated by the transfer
   assign dm_we   = (xfer0 & m0_we) | (xfer1 & m1_we);
   assign dm_addr = m0_gnt ? m0_addr  : m1_gnt ? m1_addr  : '0;
   assign dm_din  = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
   assign dm_pc   = m0_gnt ? m0_pc    : m1_gnt ? m1_pc    : '0;
   always_comb begin
      state_n = IDLE;
      unique case (state)
         IDLE:    state_n = (m0_req & m1_req) ? (last_owner ? OWN0 : OWN1) :
                            m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
         OWN0:    state_n = !m0_req ? (m1_req ? OWN1 : IDLE) : (m1_req && cap) ? OWN1 : OWN0;
         OWN1:    state_n = !m1_req ? (m0_req ? OWN0 : IDLE) : (m0_req && cap) ? OWN0 : OWN1;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         burst_cnt  <= '0;
         m0_rvalid  <= 1'b0;
         m1_rvalid  <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         state <= state_n;
         // the count saturates at the cap so a lone owner switches on its next transfer once contested
         if (state_n != state && state_n != IDLE) begin
            last_owner <= state_n == OWN1;
            burst_cnt  <= '0;
         end else if ((xfer0 | xfer1) && !cap)
            burst_cnt <= burst_cnt + CW'(1);
         m0_rvalid <= xfer0 & ~m0_we;
         m1_rvalid <= xfer1 & ~m1_we;
         if (xfer0 & ~m0_we) m0_rdata <= dm_dout;
         if (xfer1 & ~m1_we) m1_rdata <= dm_dout;
      end
   end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural dm and a read-data scoreboard.
module tb_dm_arbiter;
   logic        clk = 1'b0, reset = 1'b0;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [9:0]  m0_addr = 0, m1_addr = 0;
   logic [31:0] m0_wdata = 0, m1_wdata = 0, m0_pc = 0, m1_pc = 0;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dm_we;
   logic [31:0] m0_rdata, m1_rdata, dm_din, dm_pc, dm_dout;
   logic [9:0]  dm_addr;
   logic [1:0]  owner;
   logic [31:0] mem [1024];
   logic [31:0] model [1024];
   logic [31:0] q0 [$], q1 [$];
   int          checks = 0, errors = 0;

   dm_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_pc(dm_pc), .dm_dout(dm_dout),
      .owner(owner)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;
   assign dm_dout = mem[dm_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic sample;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (m0_rvalid) begin
         if (q0.size() == 0) chk("m0_rvalid_unexpected", 32'd1, 32'd0);
         else chk("m0_rdata_sb", m0_rdata, q0.pop_front());
      end
      if (m1_rvalid) begin
         if (q1.size() == 0) chk("m1_rvalid_unexpected", 32'd1, 32'd0);
         else chk("m1_rdata_sb", m1_rdata, q1.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]   = 32'hA500_0000 + i;
         model[i] = 32'hA500_0000 + i;
      end
      // reset held with an active write request
      m0_req = 1; m0_we = 1; m0_addr = 10'h005; m0_wdata = 32'h1111_1111; m0_pc = 32'h100;
      repeat (3) tick;
      sample;
      chk("rst_m0_gnt", {31'd0, m0_gnt}, 0);
      chk("rst_m1_gnt", {31'd0, m1_gnt}, 0);
      chk("rst_owner", {30'd0, owner}, 0);
      chk("rst_dm_we", {31'd0, dm_we}, 0);
      chk("rst_dm_addr", {22'd0, dm_addr}, 0);
      chk("rst_dm_din", dm_din, 0);
      chk("rst_dm_pc", dm_pc, 0);
      chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 0);
      chk("rst_rdata", m0_rdata | m1_rdata, 0);
      tick; reset = 1;
      sample;
      chk("rel_gnt_before_edge", {31'd0, m0_gnt}, 0);
      tick;
      sample;
      chk("rel_m0_gnt", {31'd0, m0_gnt}, 1);
      chk("rel_owner", {30'd0, owner}, 2'b01);
      chk("rel_dm_we", {31'd0, dm_we}, 1);
      model[5] = 32'h1111_1111;
      tick; m0_req = 0;
      sample;
      chk("bubble_gnt", {31'd0, m0_gnt}, 1);
      chk("bubble_dm_we", {31'd0, dm_we}, 0);
      chk("mem5", mem[5], model[5]);
      tick;
      // single write then read
      tick; m0_req = 1; m0_we = 1; m0_addr = 10'h004; m0_wdata = 32'hDEAD_BEEF;
      sample;
      chk("wr_gnt_not_yet", {31'd0, m0_gnt}, 0);
      tick;
      sample;
      chk("wr_dm_we", {31'd0, dm_we}, 1);
      chk("wr_dm_addr", {22'd0, dm_addr}, 32'h004);
      chk("wr_dm_din", dm_din, 32'hDEAD_BEEF);
      tick; m0_we = 0; model[4] = 32'hDEAD_BEEF; q0.push_back(model[4]);
      sample;
      chk("rd_dm_we", {31'd0, dm_we}, 0);
      tick; m0_req = 0;
      sample;
      chk("rd_rvalid", {31'd0, m0_rvalid}, 1);
      chk("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
      tick;
      sample;
      chk("rd_rvalid_pulse", {31'd0, m0_rvalid}, 0);
      chk("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
      // tie from IDLE after reset: m0 first, then bubble, then m1
      tick; reset = 0;
      tick; reset = 1;
      m0_req = 1; m0_we = 1; m0_addr = 10'h008; m0_wdata = 32'h33; m0_pc = 32'h200;
      m1_req = 1; m1_we = 1; m1_addr = 10'h009; m1_wdata = 32'h44; m1_pc = 32'h300;
      sample;
      chk("tie_idle", {30'd0, owner}, 0);
      tick;
      sample;
      chk("tie_owner_m0", {30'd0, owner}, 2'b01);
      chk("tie_dm_pc0", dm_pc, 32'h200);
      model[8] = 32'h33;
      tick; m0_req = 0;
      sample;
      chk("tie_bubble", {m0_gnt, m1_gnt, dm_we}, 3'b100);
      tick;
      sample;
      chk("tie_owner_m1", {30'd0, owner}, 2'b10);
      chk("tie_dm_addr1", {22'd0, dm_addr}, 32'h009);
      chk("tie_dm_pc1", dm_pc, 32'h300);
      model[9] = 32'h44;
      tick; m1_req = 0;
      tick;
      // fairness: both hold req, alternating bursts of four with no dead cycle
      tick;
      m0_req = 1; m0_we = 1; m0_addr = 10'h00A; m0_wdata = 32'h55; m0_pc = 32'h400;
      m1_req = 1; m1_we = 1; m1_addr = 10'h00B; m1_wdata = 32'h66; m1_pc = 32'h500;
      for (int i = 0; i < 16; i++) begin
         tick;
         sample;
         chk($sformatf("fair_owner_%0d", i), {30'd0, owner}, ((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("fair_pc_%0d", i), dm_pc, ((i / 4) % 2 == 0) ? 32'h400 : 32'h500);
         chk($sformatf("fair_we_%0d", i), {31'd0, dm_we}, 1);
      end
      model[10] = 32'h55; model[11] = 32'h66;
      tick; m0_req = 0; m1_req = 0;
      tick;
      // m1 read stream
      tick; m1_req = 1; m1_we = 0; m1_addr = 10'h000;
      tick; q1.push_back(model[0]);
      sample;
      chk("rs_gnt1", {31'd0, m1_gnt}, 1);
      for (int i = 1; i < 4; i++) begin
         tick; m1_addr = 10'(i); q1.push_back(model[i]);
         sample;
         chk($sformatf("rs_rvalid_%0d", i), {30'd0, m0_rvalid, m1_rvalid}, 2'b01);
      end
      tick; m1_req = 0;
      sample;
      chk("rs_rvalid_4", {30'd0, m0_rvalid, m1_rvalid}, 2'b01);
      tick;
      sample;
      chk("rs_rvalid_end", {31'd0, m1_rvalid}, 0);
      chk("rs_rdata_hold", m1_rdata, model[3]);
      // reset in the middle of an m1 write
      tick; m1_req = 1; m1_we = 1; m1_addr = 10'h00C; m1_wdata = 32'hBAD0_BAD0;
      tick;
      sample;
      chk("mr_dm_we_before", {31'd0, dm_we}, 1);
      #1 reset = 0;
      #1;
      chk("mr_dm_we_async", {31'd0, dm_we}, 0);
      chk("mr_owner_async", {30'd0, owner}, 0);
      tick;
      chk("mr_mem_unchanged", mem[12], model[12]);
      m0_req = 1; m0_we = 0; m0_addr = 10'h00C;
      m1_we = 0;
      tick; reset = 1;
      tick; q0.push_back(model[12]);
      sample;
      chk("mr_m0_wins", {30'd0, owner}, 2'b01);
      tick; m0_req = 0;
      tick; q1.push_back(model[12]);
      sample;
      chk("mr_m1_next", {30'd0, owner}, 2'b10);
      tick; m1_req = 0;
      tick;
      tick;
      chk("sb_q0_empty", q0.size(), 0);
      chk("sb_q1_empty", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
